// File: rtl/sprite_bitmap_store.sv
// Animated sprite bitmap store: per-pixel lookup with 1-cycle latency,
// vsync-paced frame advance and a valid/ready row write port.
module sprite_bitmap_store #(
    parameter int FRAME_LEN   = 2,
    parameter int FRAME_TIME  = 30,
    parameter int SPRITE_SIZE = 16,
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync,
    input  logic          anim_en,
    input  logic [3:0]    yin,
    input  logic [3:0]    xin,
    output logic          pix,
    output logic [FW-1:0] frame,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [FW-1:0] wr_frame,
    input  logic [3:0]    wr_row,
    input  logic [15:0]   wr_data,
    output logic          busy
);

    localparam int DEPTH = FRAME_LEN * SPRITE_SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int TW    = $clog2(FRAME_TIME + 1);

    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [FW-1:0] FLAST = FW'(FRAME_LEN - 1);
    localparam logic [FW:0]   FLEN  = (FW + 1)'(FRAME_LEN);
    localparam logic [TW-1:0] TLAST = TW'(FRAME_TIME - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] ptr;
    logic [15:0]   mem [DEPTH];
    logic          vsync_q;
    logic [TW-1:0] tick;
    logic          vs_edge;
    logic          wr_fire;
    logic          wr_keep;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;

    assign vs_edge = vsync & ~vsync_q;
    assign wr_fire = wr_valid & wr_ready;
    // Out-of-range frames still complete the handshake, data is dropped
    assign wr_keep = wr_fire & ({1'b0, wr_frame} < FLEN);
    assign raddr   = AW'({frame, yin});
    assign waddr   = AW'({wr_frame, wr_row});

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        wr_ready  = 1'b0;
        unique case (state)
            CLEAR: begin
                busy = 1'b1;
                if (ptr == LAST)
                    state_nxt = IDLE;
            end
            IDLE: wr_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                ptr <= ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[ptr] <= '0;
        else if (wr_keep)
            mem[waddr] <= wr_data;
    end

    // Read-before-write: a same-cycle write is seen on the next lookup
    always_ff @(posedge clk) begin
        if (reset || state == CLEAR)
            pix <= 1'b0;
        else
            pix <= mem[raddr][~xin];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q <= 1'b0;
            tick    <= '0;
            frame   <= '0;
        end else begin
            vsync_q <= vsync;
            if (vs_edge && anim_en) begin
                if (tick == TLAST) begin
                    tick  <= '0;
                    frame <= (frame == FLAST) ? '0 : frame + FW'(1);
                end else begin
                    tick <= tick + TW'(1);
                end
            end
        end
    end

endmodule
